nand_flash_fsm: RTL and testbench

- Low-level NAND flash bus sequencer between the host-side register block and an 8-bit asynchronous NAND device.
- The host issues one primitive at a time through a control byte: command latch, address latch, data-write burst, data-read burst, or wait-ready.
- The block generates nCE/CLE/ALE/nWE/nRE/nWP timing and drives or samples the bidirectional DIO bus.
- The block has no busy output. Every primitive has a fixed, documented cycle count, and the host paces itself by that count.

---
 rtl/nand_pkg.sv | 34 +++
 rtl/nand_io_buf.sv | 34 +++
 rtl/nand_flash_fsm.sv | 273 +++++++++++++++++++++++++++
 tb/tb_nand_flash_fsm.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND flash bus sequencer.
package nand_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WE_LOW   = 3'd2,
    ST_WE_HIGH  = 3'd3,
    ST_RE_LOW   = 3'd4,
    ST_RE_HIGH  = 3'd5,
    ST_WB_DELAY = 3'd6,
    ST_WAIT_RB  = 3'd7
  } nand_state_e;

  // Primitive opcodes carried in C_Status[2:0]; 110/111 behave as NOP
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CMD     = 3'd1;
  localparam logic [2:0] OP_ADDR    = 3'd2;
  localparam logic [2:0] OP_WRITE   = 3'd3;
  localparam logic [2:0] OP_READ    = 3'd4;
  localparam logic [2:0] OP_WAIT_RB = 3'd5;

  // C_Status bit positions
  localparam int START   = 7;
  localparam int CE_HOLD = 6;
  localparam int WP_OFF  = 5;

  // True for the primitives that put a byte on DIO
  function automatic logic op_drives_bus(input logic [2:0] op);
    return (op == OP_CMD) || (op == OP_ADDR) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/nand_io_buf.sv
// DIO tristate driver: registered output enable and output data byte.
module nand_io_buf (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_oe_set,
  input  logic       i_oe_clr,
  input  logic       i_ld,
  input  logic [7:0] i_data,
  inout  wire  [7:0] io_dio
);

  logic       r_oe;
  logic [7:0] r_data;

  // Enable and data registers; set wins over clear, bus released in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oe   <= 1'b0;
      r_data <= 8'h00;
    end else begin
      if (i_oe_set) begin
        r_oe <= 1'b1;
      end else if (i_oe_clr) begin
        r_oe <= 1'b0;
      end
      if (i_ld) begin
        r_data <= i_data;
      end
    end
  end

  assign io_dio = r_oe ? r_data : 8'bzzzz_zzzz;

endmodule

// File: rtl/nand_flash_fsm.sv
// NAND flash bus sequencer: one primitive per START edge, fixed cycle counts.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a START rising edge
// ST_SETUP    | 1 cycle: byte on DIO, CLE/ALE set up, counters loaded
// ST_WE_LOW   | nWE low for TWP cycles (CMD/ADDR/WRITE byte)
// ST_WE_HIGH  | nWE high for TWH cycles, then next byte or IDLE
// ST_RE_LOW   | nRE low for TRP cycles, DIO captured on the last one
// ST_RE_HIGH  | nRE high for TREH cycles, then next byte or IDLE
// ST_WB_DELAY | TWB cycles before the ready line is trusted
// ST_WAIT_RB  | hold until synchronised nRB reads ready
module nand_flash_fsm
  import nand_pkg::*;
#(
  parameter int TWP  = 2,
  parameter int TWH  = 2,
  parameter int TRP  = 2,
  parameter int TREH = 2,
  parameter int TWB  = 4
) (
  input  logic       P_clk,
  input  logic       P_nrst,
  input  logic [7:0] C_Cmd,
  input  logic [7:0] C_Addr,
  input  logic [7:0] C_Length,
  input  logic [7:0] C_Status,
  input  logic [7:0] C_WrData,
  output logic [7:0] C_RdData,
  output logic       F_nCE,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_nWE,
  output logic       F_nRE,
  output logic       F_nWP,
  input  logic       F_nRB,
  inout  wire  [7:0] F_DIO
);

  // Down-counter reload values: a phase lasting N cycles loads N-1
  localparam logic [7:0] CNT_TWP  = 8'(TWP - 1);
  localparam logic [7:0] CNT_TWH  = 8'(TWH - 1);
  localparam logic [7:0] CNT_TRP  = 8'(TRP - 1);
  localparam logic [7:0] CNT_TREH = 8'(TREH - 1);
  localparam logic [7:0] CNT_TWB  = 8'(TWB - 1);

  nand_state_e r_state;
  logic [2:0]  r_op;
  logic [7:0]  r_cnt;
  logic [7:0]  r_bytes;
  logic        r_nce;
  logic        r_cle;
  logic        r_ale;
  logic        r_nwe;
  logic        r_nre;
  logic        r_nwp;
  logic [7:0]  r_rddata;
  logic        r_start_q;
  logic        r_rb_meta;
  logic        r_rb_sync;

  logic        w_start;
  logic        w_cnt_done;
  logic        w_more_wr;
  logic        w_oe_set;
  logic        w_oe_clr;
  logic        w_ld;
  logic [7:0]  w_ld_data;
  logic [1:0]  w_unused_status;

  assign w_unused_status = C_Status[4:3];

  assign w_start    = (r_state == ST_IDLE) && C_Status[START] && !r_start_q;
  assign w_cnt_done = (r_cnt == 8'd0);
  assign w_more_wr  = (r_op == OP_WRITE) && (r_bytes != 8'd0);
  assign w_oe_set   = w_start && op_drives_bus(C_Status[2:0]);
  assign w_oe_clr   = ((r_state == ST_SETUP) && (r_op == OP_WRITE) && (r_bytes == 8'd0)) ||
                      ((r_state == ST_WE_HIGH) && w_cnt_done && !w_more_wr);

  // DIO data loads: the op's byte at start, then each write byte on entry to WE_LOW
  always_comb begin
    w_ld      = 1'b0;
    w_ld_data = C_WrData;
    if (w_oe_set) begin
      w_ld = 1'b1;
      if (C_Status[2:0] == OP_CMD) begin
        w_ld_data = C_Cmd;
      end else if (C_Status[2:0] == OP_ADDR) begin
        w_ld_data = C_Addr;
      end
    end else if ((r_state == ST_SETUP) && w_more_wr) begin
      w_ld = 1'b1;
    end else if ((r_state == ST_WE_HIGH) && w_cnt_done && w_more_wr) begin
      w_ld = 1'b1;
    end
  end

  // START edge detect and write-protect follow the control byte every cycle
  always_ff @(posedge P_clk or negedge P_nrst) begin
    if (!P_nrst) begin
      r_start_q <= 1'b0;
      r_nwp     <= 1'b0;
    end else begin
      r_start_q <= C_Status[START];
      r_nwp     <= C_Status[WP_OFF];
    end
  end

  // Two-flop synchroniser for the asynchronous ready/busy line
  always_ff @(posedge P_clk or negedge P_nrst) begin
    if (!P_nrst) begin
      r_rb_meta <= 1'b0;
      r_rb_sync <= 1'b0;
    end else begin
      r_rb_meta <= F_nRB;
      r_rb_sync <= r_rb_meta;
    end
  end

  // Sequencer with cycle/byte down-counters and registered bus strobes
  always_ff @(posedge P_clk or negedge P_nrst) begin
    if (!P_nrst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_cnt    <= 8'd0;
      r_bytes  <= 8'd0;
      r_nce    <= 1'b1;
      r_cle    <= 1'b0;
      r_ale    <= 1'b0;
      r_nwe    <= 1'b1;
      r_nre    <= 1'b1;
      r_rddata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_nce <= ~C_Status[CE_HOLD];
          if (w_start) begin
            r_op    <= C_Status[2:0];
            r_bytes <= C_Length;
            case (C_Status[2:0])
              OP_CMD: begin
                r_state <= ST_SETUP;
                r_cle   <= 1'b1;
                r_nce   <= 1'b0;
              end
              OP_ADDR: begin
                r_state <= ST_SETUP;
                r_ale   <= 1'b1;
                r_nce   <= 1'b0;
              end
              OP_WRITE, OP_READ: begin
                r_state <= ST_SETUP;
                r_nce   <= 1'b0;
              end
              OP_WAIT_RB: begin
                r_state <= ST_WB_DELAY;
                r_cnt   <= CNT_TWB;
                r_nce   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_SETUP: begin
          if ((r_op == OP_READ) || (r_op == OP_WRITE)) begin
            if (r_bytes == 8'd0) begin
              r_state <= ST_IDLE;
              r_nce   <= ~C_Status[CE_HOLD];
            end else if (r_op == OP_READ) begin
              r_state <= ST_RE_LOW;
              r_nre   <= 1'b0;
              r_cnt   <= CNT_TRP;
            end else begin
              r_state <= ST_WE_LOW;
              r_nwe   <= 1'b0;
              r_cnt   <= CNT_TWP;
            end
          end else begin
            r_state <= ST_WE_LOW;
            r_nwe   <= 1'b0;
            r_cnt   <= CNT_TWP;
          end
        end
        ST_WE_LOW: begin
          if (w_cnt_done) begin
            r_state <= ST_WE_HIGH;
            r_nwe   <= 1'b1;
            r_cnt   <= CNT_TWH;
            if (r_op == OP_WRITE) begin
              r_bytes <= r_bytes - 8'd1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_WE_HIGH: begin
          if (w_cnt_done) begin
            if (w_more_wr) begin
              r_state <= ST_WE_LOW;
              r_nwe   <= 1'b0;
              r_cnt   <= CNT_TWP;
            end else begin
              r_state <= ST_IDLE;
              r_cle   <= 1'b0;
              r_ale   <= 1'b0;
              r_nce   <= ~C_Status[CE_HOLD];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RE_LOW: begin
          if (w_cnt_done) begin
            r_rddata <= F_DIO;
            r_state  <= ST_RE_HIGH;
            r_nre    <= 1'b1;
            r_cnt    <= CNT_TREH;
            r_bytes  <= r_bytes - 8'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RE_HIGH: begin
          if (w_cnt_done) begin
            if (r_bytes != 8'd0) begin
              r_state <= ST_RE_LOW;
              r_nre   <= 1'b0;
              r_cnt   <= CNT_TRP;
            end else begin
              r_state <= ST_IDLE;
              r_nce   <= ~C_Status[CE_HOLD];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_WB_DELAY: begin
          if (w_cnt_done) begin
            r_state <= ST_WAIT_RB;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_WAIT_RB: begin
          if (r_rb_sync) begin
            r_state <= ST_IDLE;
            r_nce   <= ~C_Status[CE_HOLD];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  nand_io_buf u_io (
    .i_clk    (P_clk),
    .i_rst_n  (P_nrst),
    .i_oe_set (w_oe_set),
    .i_oe_clr (w_oe_clr),
    .i_ld     (w_ld),
    .i_data   (w_ld_data),
    .io_dio   (F_DIO)
  );

  assign C_RdData = r_rddata;
  assign F_nCE    = r_nce;
  assign F_CLE    = r_cle;
  assign F_ALE    = r_ale;
  assign F_nWE    = r_nwe;
  assign F_nRE    = r_nre;
  assign F_nWP    = r_nwp;

endmodule

// File: tb/tb_nand_flash_fsm.sv
// Self-checking bench for nand_flash_fsm: scoreboard of bus pulses plus per-cycle patterns.
module tb_nand_flash_fsm;

  localparam int TWP = 2;
  localparam logic [2:0] T_CMD = 3'd1, T_ADDR = 3'd2, T_WRITE = 3'd3, T_READ = 3'd4, T_WAITRB = 3'd5;

  logic       P_clk = 1'b0;
  logic       P_nrst;
  logic [7:0] C_Cmd, C_Addr, C_Length, C_Status, C_WrData;
  wire  [7:0] C_RdData;
  wire        F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP;
  logic       F_nRB;
  wire  [7:0] F_DIO;

  logic       fl_oe = 1'b0;
  logic [7:0] fl_drv = 8'h00;
  logic [7:0] fl_q[$];
  assign F_DIO = fl_oe ? fl_drv : 8'bzzzz_zzzz;

  nand_flash_fsm dut (
    .P_clk(P_clk), .P_nrst(P_nrst), .C_Cmd(C_Cmd), .C_Addr(C_Addr), .C_Length(C_Length),
    .C_Status(C_Status), .C_WrData(C_WrData), .C_RdData(C_RdData), .F_nCE(F_nCE),
    .F_CLE(F_CLE), .F_ALE(F_ALE), .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP),
    .F_nRB(F_nRB), .F_DIO(F_DIO)
  );

  always #5 P_clk = ~P_clk;

  typedef struct { logic [7:0] data; logic cle; logic ale; int len; } we_obs_t;
  typedef struct { logic [7:0] data; logic cle; logic ale; } we_exp_t;
  typedef struct { logic [7:0] rd; int len; } re_obs_t;

  we_obs_t    obs_we_q[$];
  we_exp_t    exp_we_q[$];
  re_obs_t    obs_re_q[$];
  logic [7:0] exp_rd_q[$];

  int checks = 0;
  int failures = 0;
  int excl_viol = 0;

  // Flash model: returns the next queued byte while nRE is low
  always @(F_nRE) begin
    if (F_nRE === 1'b0 && fl_q.size() > 0) begin
      fl_drv = fl_q.pop_front();
      fl_oe  = 1'b1;
    end else begin
      fl_oe = 1'b0;
    end
  end

  // Bus monitor: turns completed nWE / nRE pulses into observations
  always @(negedge P_clk) begin : mon
    int we_len, re_len;
    logic [7:0] we_data;
    logic we_cle, we_ale;
    we_obs_t wo;
    re_obs_t ro;
    if (!P_nrst) begin
      we_len = 0;
      re_len = 0;
    end else begin
      if (F_CLE && F_ALE) excl_viol++;
      if (!F_nWE && !F_nRE) excl_viol++;
      if (!F_nWE) begin
        we_len++;
        we_data = F_DIO;
        we_cle  = F_CLE;
        we_ale  = F_ALE;
      end else if (we_len > 0) begin
        wo.data = we_data; wo.cle = we_cle; wo.ale = we_ale; wo.len = we_len;
        obs_we_q.push_back(wo);
        we_len = 0;
      end
      if (!F_nRE) begin
        re_len++;
      end else if (re_len > 0) begin
        ro.rd = C_RdData; ro.len = re_len;
        obs_re_q.push_back(ro);
        re_len = 0;
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic ce_hold, input logic wp_off);
    @(negedge P_clk);
    C_Status = {1'b0, ce_hold, wp_off, 2'b00, op};
    @(negedge P_clk);
    C_Status[7] = 1'b1;
  endtask

  task automatic test_reset();
    P_nrst = 1'b0; C_Cmd = 0; C_Addr = 0; C_Length = 0; C_WrData = 0; F_nRB = 1'b1;
    C_Status = 8'h20;
    #12;
    checks++;
    if ({F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, C_RdData, dut.u_io.r_oe} !== {6'b100110, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got nce/cle/ale/nwe/nre/nwp=%b%b%b%b%b%b rd=%02h oe=%b exp 100110 rd=00 oe=0",
               F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, C_RdData, dut.u_io.r_oe);
    end
    @(negedge P_clk);
    C_Status = 8'h00;
    @(negedge P_clk);
    P_nrst = 1'b1;
    repeat (2) @(negedge P_clk);
  endtask

  task automatic test_cmd();
    logic [7:0] b [2];
    logic [5:0] p_nwe, p_cle, p_ale, p_nce;
    we_obs_t o;
    we_exp_t e;
    b[0] = 8'h00; b[1] = 8'h30;
    for (int k = 0; k < 2; k++) begin
      C_Cmd = b[k];
      e.data = b[k]; e.cle = 1'b1; e.ale = 1'b0;
      exp_we_q.push_back(e);
      start_op(T_CMD, 1'b0, 1'b0);
      p_nwe = '0; p_cle = '0; p_ale = '0; p_nce = '0;
      for (int i = 0; i < 6; i++) begin
        @(negedge P_clk);
        p_nwe = {p_nwe[4:0], F_nWE}; p_cle = {p_cle[4:0], F_CLE};
        p_ale = {p_ale[4:0], F_ALE}; p_nce = {p_nce[4:0], F_nCE};
      end
      C_Status[7] = 1'b0;
      checks++;
      if ({p_nwe, p_cle, p_ale, p_nce} !== {6'b100111, 6'b111110, 6'b000000, 6'b000001}) begin
        failures++;
        $display("FAIL cmd%0d_timing got nwe=%b cle=%b ale=%b nce=%b exp nwe=100111 cle=111110 ale=000000 nce=000001",
                 k, p_nwe, p_cle, p_ale, p_nce);
      end
      repeat (2) @(negedge P_clk);
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_we_q.pop_front();
      checks++;
      if (obs_we_q.size() == 0) begin
        failures++;
        $display("FAIL cmd%0d_pulse got no nWE pulse exp data=%02h", k, e.data);
      end else begin
        o = obs_we_q.pop_front();
        if (o.data !== e.data || o.cle !== e.cle || o.ale !== e.ale || o.len != TWP) begin
          failures++;
          $display("FAIL cmd%0d_pulse got data=%02h cle=%b ale=%b len=%0d exp data=%02h cle=%b ale=%b len=%0d",
                   k, o.data, o.cle, o.ale, o.len, e.data, e.cle, e.ale, TWP);
        end
      end
    end
  endtask

  task automatic test_addr();
    int n_nce, n_ale;
    we_obs_t o;
    we_exp_t e;
    for (int k = 0; k < 5; k++) begin
      C_Addr = 8'hA0 + 8'(k);
      e.data = 8'hA0 + 8'(k); e.cle = 1'b0; e.ale = 1'b1;
      exp_we_q.push_back(e);
      start_op(T_ADDR, 1'b0, 1'b0);
      n_nce = 0; n_ale = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge P_clk);
        if (!F_nCE) n_nce++;
        if (F_ALE) n_ale++;
      end
      C_Status[7] = 1'b0;
      checks++;
      if (n_nce != 5 || n_ale != 5) begin
        failures++;
        $display("FAIL addr%0d_window got nce_low=%0d ale_high=%0d exp 5 and 5", k, n_nce, n_ale);
      end
      repeat (12) @(negedge P_clk);
    end
    for (int k = 0; k < 5; k++) begin
      e = exp_we_q.pop_front();
      checks++;
      if (obs_we_q.size() == 0) begin
        failures++;
        $display("FAIL addr%0d_pulse got no nWE pulse exp data=%02h", k, e.data);
      end else begin
        o = obs_we_q.pop_front();
        if (o.data !== e.data || o.cle !== e.cle || o.ale !== e.ale || o.len != TWP) begin
          failures++;
          $display("FAIL addr%0d_pulse got data=%02h cle=%b ale=%b len=%0d exp data=%02h cle=%b ale=%b len=%0d",
                   k, o.data, o.cle, o.ale, o.len, e.data, e.cle, e.ale, TWP);
        end
      end
    end
  endtask

  task automatic test_read();
    logic [13:0] p_nre;
    int n_drv;
    re_obs_t o;
    logic [7:0] e;
    fl_q.push_back(8'h11); fl_q.push_back(8'h22); fl_q.push_back(8'h33);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22); exp_rd_q.push_back(8'h33);
    C_Length = 8'd3;
    start_op(T_READ, 1'b0, 1'b0);
    p_nre = '0; n_drv = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge P_clk);
      p_nre = {p_nre[12:0], F_nRE};
      if (dut.u_io.r_oe !== 1'b0) n_drv++;
    end
    C_Status[7] = 1'b0;
    checks++;
    if (p_nre !== 14'b10011001100111) begin
      failures++;
      $display("FAIL read_nre_pattern got %b exp 10011001100111", p_nre);
    end
    checks++;
    if (n_drv != 0) begin
      failures++;
      $display("FAIL read_bus_driven got %0d driven cycles exp 0", n_drv);
    end
    checks++;
    if (C_RdData !== 8'h33) begin
      failures++;
      $display("FAIL read_final_data got %02h exp 33", C_RdData);
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_re_q.size() == 0) begin
        failures++;
        $display("FAIL read%0d_byte got no nRE pulse exp %02h", k, e);
      end else begin
        o = obs_re_q.pop_front();
        if (o.rd !== e || o.len != 2) begin
          failures++;
          $display("FAIL read%0d_byte got rd=%02h len=%0d exp rd=%02h len=2", k, o.rd, o.len, e);
        end
      end
    end
    repeat (2) @(negedge P_clk);
  endtask

  task automatic test_wait_rb();
    int n;
    bit seen, busy_lost;
    F_nRB = 1'b1;
    start_op(T_WAITRB, 1'b0, 1'b0);
    n = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge P_clk);
      if (F_nCE) seen = 1; else n++;
    end
    C_Status[7] = 1'b0;
    checks++;
    if (!seen || n != 5) begin
      failures++;
      $display("FAIL waitrb_ready_len got busy_cycles=%0d done=%0d exp busy_cycles=5 done=1", n, seen);
    end
    F_nRB = 1'b0;
    C_Cmd = 8'hEE;
    start_op(T_WAITRB, 1'b0, 1'b0);
    busy_lost = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge P_clk);
      if (F_nCE) busy_lost = 1;
      if (i == 10) C_Status[7] = 1'b0;
      if (i == 11) C_Status = {1'b1, 4'b0000, T_CMD};
    end
    checks++;
    if (busy_lost) begin
      failures++;
      $display("FAIL waitrb_busy got nCE high while nRB=0 exp nCE low throughout");
    end
    F_nRB = 1'b1;
    n = 0; seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge P_clk);
      if (F_nCE) begin seen = 1; n = i; end
    end
    checks++;
    if (!seen || n < 2 || n > 3) begin
      failures++;
      $display("FAIL waitrb_release got cycles=%0d done=%0d exp cycles 2..3 done=1", n, seen);
    end
    repeat (8) @(negedge P_clk);
    checks++;
    if (obs_we_q.size() != 0 || F_nCE !== 1'b1) begin
      failures++;
      $display("FAIL waitrb_ignored_start got pulses=%0d nce=%b exp pulses=0 nce=1", obs_we_q.size(), F_nCE);
    end
    C_Status[7] = 1'b0;
    repeat (2) @(negedge P_clk);
  endtask

  task automatic test_write();
    logic [5:0] z_nwe, z_nce;
    logic [9:0] p_nwe, p_nce;
    we_obs_t o;
    we_exp_t e;
    C_Length = 8'd0;
    start_op(T_WRITE, 1'b0, 1'b1);
    z_nwe = '0; z_nce = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge P_clk);
      z_nwe = {z_nwe[4:0], F_nWE}; z_nce = {z_nce[4:0], F_nCE};
    end
    C_Status[7] = 1'b0;
    checks++;
    if (z_nwe !== 6'b111111 || z_nce !== 6'b011111) begin
      failures++;
      $display("FAIL write0_timing got nwe=%b nce=%b exp nwe=111111 nce=011111", z_nwe, z_nce);
    end
    checks++;
    if (F_nWP !== 1'b1) begin
      failures++;
      $display("FAIL write0_nwp got %b exp 1", F_nWP);
    end
    C_Length = 8'd2;
    C_WrData = 8'hC3;
    e.cle = 1'b0; e.ale = 1'b0;
    e.data = 8'hC3; exp_we_q.push_back(e);
    e.data = 8'h3C; exp_we_q.push_back(e);
    start_op(T_WRITE, 1'b0, 1'b1);
    p_nwe = '0; p_nce = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge P_clk);
      p_nwe = {p_nwe[8:0], F_nWE}; p_nce = {p_nce[8:0], F_nCE};
      if (i == 2) C_WrData = 8'h3C;
    end
    C_Status[7] = 1'b0;
    checks++;
    if (p_nwe !== 10'b1001100111 || p_nce !== 10'b0000000001) begin
      failures++;
      $display("FAIL write2_timing got nwe=%b nce=%b exp nwe=1001100111 nce=0000000001", p_nwe, p_nce);
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_we_q.pop_front();
      checks++;
      if (obs_we_q.size() == 0) begin
        failures++;
        $display("FAIL write%0d_pulse got no nWE pulse exp data=%02h", k, e.data);
      end else begin
        o = obs_we_q.pop_front();
        if (o.data !== e.data || o.cle !== e.cle || o.ale !== e.ale || o.len != TWP) begin
          failures++;
          $display("FAIL write%0d_pulse got data=%02h cle=%b ale=%b len=%0d exp data=%02h cle=0 ale=0 len=%0d",
                   k, o.data, o.cle, o.ale, o.len, e.data, TWP);
        end
      end
    end
    checks++;
    if (obs_we_q.size() != 0) begin
      failures++;
      $display("FAIL write_extra_pulses got %0d exp 0", obs_we_q.size());
    end
    repeat (2) @(negedge P_clk);
  endtask

  task automatic test_reset_midop();
    C_Length = 8'd3;
    C_WrData = 8'h5A;
    start_op(T_WRITE, 1'b0, 1'b1);
    repeat (3) @(negedge P_clk);
    checks++;
    if (F_nWE !== 1'b0 || dut.u_io.r_oe !== 1'b1 || F_DIO !== 8'h5A) begin
      failures++;
      $display("FAIL midop_precondition got nwe=%b oe=%b dio=%02h exp nwe=0 oe=1 dio=5A", F_nWE, dut.u_io.r_oe, F_DIO);
    end
    #1 P_nrst = 1'b0;
    #1;
    checks++;
    if ({F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, C_RdData, dut.u_io.r_oe} !== {6'b100110, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL midop_reset got nce/cle/ale/nwe/nre/nwp=%b%b%b%b%b%b rd=%02h oe=%b exp 100110 rd=00 oe=0",
               F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, C_RdData, dut.u_io.r_oe);
    end
    repeat (2) @(negedge P_clk);
    C_Status = 8'h00;
    P_nrst = 1'b1;
    obs_we_q.delete();
    exp_we_q.delete();
    repeat (3) @(negedge P_clk);
    checks++;
    if (F_nCE !== 1'b1 || F_nWE !== 1'b1) begin
      failures++;
      $display("FAIL midop_after_reset got nce=%b nwe=%b exp nce=1 nwe=1", F_nCE, F_nWE);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (excl_viol != 0) begin
      failures++;
      $display("FAIL bus_exclusion got %0d violations exp 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_addr();
    test_read();
    test_wait_rb();
    test_write();
    test_reset_midop();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
